// File: rtl/strobe_decoder_n.sv
// strobe_decoder_n: CHANNELS independent SEL_W-to-2^SEL_W decoders with
// active-low one-hot outputs. Each channel either decodes continuously
// (level mode) or emits a timed strobe of programmable length (pulse mode).
//
// Start handshake: a pulse-mode request is accepted on a rising clk edge
// where start=1, en_n=0, mode=1 and the channel is IDLE (busy=0). There is
// no back-pressure signal; a start that is not accepted is simply dropped.
// Once accepted, busy stays high for the whole strobe, and completion is
// reported by a single-cycle done (an abort through en_n gives no done).
module strobe_decoder_n #(
  parameter int CHANNELS = 2,
  parameter int SEL_W    = 2,
  parameter int LEN_W    = 4
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [CHANNELS-1:0]             en_n,
  input  logic [CHANNELS-1:0]             mode,
  input  logic [CHANNELS*SEL_W-1:0]       sel,
  input  logic [CHANNELS-1:0]             start,
  input  logic [CHANNELS*LEN_W-1:0]       pulse_len,
  output logic [CHANNELS*(2**SEL_W)-1:0]  y_n,
  output logic [CHANNELS-1:0]             busy,
  output logic [CHANNELS-1:0]             done,
  output logic [CHANNELS-1:0]             state_dbg
);

  localparam int OUTS = 2**SEL_W;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  // Active-low one-hot decode of a select value.
  function automatic logic [OUTS-1:0] dec_low(input logic [SEL_W-1:0] s);
    dec_low = ~({{(OUTS-1){1'b0}}, 1'b1} << s);
  endfunction

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    state_t             state;
    logic [SEL_W-1:0]   sel_q;
    logic [LEN_W-1:0]   cnt;
    logic [OUTS-1:0]    y_r;
    logic               busy_r;
    logic               done_r;
    logic [SEL_W-1:0]   sel_c;
    logic [LEN_W-1:0]   len_c;

    assign sel_c = sel[c*SEL_W +: SEL_W];
    assign len_c = pulse_len[c*LEN_W +: LEN_W];

    // Per-channel FSM: level decode or pulse strobe, all outputs registered.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        state  <= IDLE;
        sel_q  <= '0;
        cnt    <= '0;
        y_r    <= '1;
        busy_r <= 1'b0;
        done_r <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            done_r <= 1'b0;
            if (mode[c] && start[c] && !en_n[c]) begin
              // Length 0 behaves as a one-cycle strobe.
              state  <= ACTIVE;
              sel_q  <= sel_c;
              cnt    <= (len_c == '0) ? LEN_W'(1) : len_c;
              y_r    <= dec_low(sel_c);
              busy_r <= 1'b1;
            end else if (mode[c] || en_n[c]) begin
              y_r    <= '1;
              busy_r <= 1'b0;
            end else begin
              y_r    <= dec_low(sel_c);
              busy_r <= 1'b0;
            end
          end
          ACTIVE: begin
            if (en_n[c]) begin
              // Abort: strobe ends at once and no completion is flagged.
              state  <= IDLE;
              y_r    <= '1;
              busy_r <= 1'b0;
              done_r <= 1'b0;
            end else if (cnt == LEN_W'(1)) begin
              state  <= IDLE;
              y_r    <= '1;
              busy_r <= 1'b0;
              done_r <= 1'b1;
            end else begin
              cnt    <= cnt - LEN_W'(1);
              y_r    <= dec_low(sel_q);
              busy_r <= 1'b1;
              done_r <= 1'b0;
            end
          end
          default: begin
            state  <= IDLE;
            y_r    <= '1;
            busy_r <= 1'b0;
            done_r <= 1'b0;
          end
        endcase
      end
    end

    assign y_n[c*OUTS +: OUTS] = y_r;
    assign busy[c]             = busy_r;
    assign done[c]             = done_r;
    assign state_dbg[c]        = (state == ACTIVE);
  end

endmodule

// File: tb/tb_strobe_decoder_n.sv
// Testbench for strobe_decoder_n: directed scenarios with literal
// expectations plus a long random run, all compared every cycle against a
// behavioural model that tracks the remaining strobe cycles per channel.
module tb_strobe_decoder_n;

  localparam int CH   = 2;
  localparam int SW   = 2;
  localparam int LW   = 4;
  localparam int OUTS = 4;

  logic                 clk;
  logic                 reset_n;
  logic [CH-1:0]        en_n;
  logic [CH-1:0]        mode;
  logic [CH*SW-1:0]     sel;
  logic [CH-1:0]        start;
  logic [CH*LW-1:0]     pulse_len;
  logic [CH*OUTS-1:0]   y_n;
  logic [CH-1:0]        busy;
  logic [CH-1:0]        done;
  logic [CH-1:0]        state_dbg;

  int checks;
  int failures;

  strobe_decoder_n #(.CHANNELS(CH), .SEL_W(SW), .LEN_W(LW)) dut (
    .clk(clk), .reset_n(reset_n), .en_n(en_n), .mode(mode), .sel(sel),
    .start(start), .pulse_len(pulse_len), .y_n(y_n), .busy(busy),
    .done(done), .state_dbg(state_dbg)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: rem = strobe cycles still owed by the channel.
  int              rem  [CH];
  logic [OUTS-1:0] m_y  [CH];
  logic            m_b  [CH];
  logic            m_d  [CH];

  function automatic logic [OUTS-1:0] low_hot(input int s);
    logic [OUTS-1:0] one;
    one = 1;
    return ~(one << s);
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < CH; c++) begin
        rem[c] = 0; m_y[c] = '1; m_b[c] = 1'b0; m_d[c] = 1'b0;
      end
    end else begin
      for (int c = 0; c < CH; c++) begin
        int s, l;
        s = int'(sel[c*SW +: SW]);
        l = int'(pulse_len[c*LW +: LW]);
        if (rem[c] > 0) begin
          if (en_n[c]) begin
            rem[c] = 0; m_y[c] = '1; m_b[c] = 1'b0; m_d[c] = 1'b0;
          end else begin
            rem[c] = rem[c] - 1;
            m_b[c] = (rem[c] != 0);
            m_d[c] = (rem[c] == 0);
            if (rem[c] == 0) m_y[c] = '1;
          end
        end else if (mode[c] && start[c] && !en_n[c]) begin
          rem[c] = (l == 0) ? 1 : l;
          m_y[c] = low_hot(s); m_b[c] = 1'b1; m_d[c] = 1'b0;
        end else begin
          m_b[c] = 1'b0; m_d[c] = 1'b0;
          m_y[c] = (mode[c] || en_n[c]) ? '1 : low_hot(s);
        end
      end
    end
  end

  // Scoreboard: model vs DUT every cycle out of reset, plus one-hot-low check
  always @(negedge clk) begin
    if (reset_n) begin
      for (int c = 0; c < CH; c++) begin
        logic [OUTS-1:0] yc;
        yc = y_n[c*OUTS +: OUTS];
        checks++;
        if (yc !== m_y[c] || busy[c] !== m_b[c] || done[c] !== m_d[c]) begin
          failures++;
          $display("FAIL model ch%0d t=%0t got y_n=%b busy=%b done=%b exp y_n=%b busy=%b done=%b",
                   c, $time, yc, busy[c], done[c], m_y[c], m_b[c], m_d[c]);
        end
        checks++;
        if ($countones(~yc) > 1) begin
          failures++;
          $display("FAIL onehot ch%0d t=%0t y_n=%b", c, $time, yc);
        end
      end
    end
  end

  // Driver / literal-check tasks
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", name, $time, got, exp);
    end
  endtask

  task automatic set_ch(input int c, input logic e, input logic m, input int s,
                        input logic st, input int l);
    en_n[c] = e;
    mode[c] = m;
    sel[c*SW +: SW] = SW'(s);
    start[c] = st;
    pulse_len[c*LW +: LW] = LW'(l);
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  function automatic logic [3:0] y0();
    return y_n[3:0];
  endfunction

  function automatic logic [3:0] y1();
    return y_n[7:4];
  endfunction

  initial begin
    checks = 0; failures = 0;
    reset_n = 1'b0;
    en_n = '1; mode = '0; sel = '0; start = '0; pulse_len = '0;
    repeat (2) cyc();
    chk("reset_y", 32'(y_n), 32'hFF);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_done", 32'(done), 32'h0);
    reset_n = 1'b1;

    // Level mode
    set_ch(0, 1'b0, 1'b0, 2, 1'b0, 0);
    cyc(); chk("level_sel2", 32'(y0()), 32'hB);
    en_n[0] = 1'b1;
    cyc(); chk("level_dis", 32'(y0()), 32'hF);

    // Pulse basic: len 3, sel 1
    set_ch(0, 1'b0, 1'b1, 1, 1'b1, 3);
    for (int i = 0; i < 3; i++) begin
      cyc(); start[0] = 1'b0;
      chk("pulse_y", 32'(y0()), 32'hD);
      chk("pulse_busy", 32'(busy[0]), 32'h1);
    end
    cyc();
    chk("pulse_end_y", 32'(y0()), 32'hF);
    chk("pulse_done", 32'(done[0]), 32'h1);
    chk("pulse_end_busy", 32'(busy[0]), 32'h0);
    cyc(); chk("done_clear", 32'(done[0]), 32'h0);

    // Zero length, then back-to-back start in the done cycle
    set_ch(0, 1'b0, 1'b1, 0, 1'b1, 0);
    cyc(); start[0] = 1'b0;
    chk("zero_len_y", 32'(y0()), 32'hE);
    cyc();
    chk("zero_len_done", 32'(done[0]), 32'h1);
    chk("gap_high", 32'(y0()), 32'hF);
    set_ch(0, 1'b0, 1'b1, 3, 1'b1, 2);
    cyc(); start[0] = 1'b0; chk("b2b_1", 32'(y0()), 32'h7);
    cyc(); chk("b2b_2", 32'(y0()), 32'h7);
    cyc(); chk("b2b_done", 32'(done[0]), 32'h1);

    // Abort with ignored start/sel/len changes while active
    set_ch(0, 1'b0, 1'b1, 2, 1'b1, 5);
    cyc(); chk("abort_c1", 32'(y0()), 32'hB);
    sel[1:0] = 2'd0; pulse_len[3:0] = 4'd1;
    cyc(); chk("ignore_c2", 32'(y0()), 32'hB);
    en_n[0] = 1'b1; start[0] = 1'b0;
    cyc();
    chk("abort_y", 32'(y0()), 32'hF);
    chk("abort_busy", 32'(busy[0]), 32'h0);
    chk("abort_done", 32'(done[0]), 32'h0);
    cyc(); chk("abort_no_done", 32'(done[0]), 32'h0);

    // Independence: ch0 pulse len 4, ch1 level with sel changing each cycle
    set_ch(0, 1'b0, 1'b1, 1, 1'b1, 4);
    set_ch(1, 1'b0, 1'b0, 0, 1'b0, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(); start[0] = 1'b0;
      chk("indep_ch0", 32'(y0()), 32'hD);
      chk("indep_ch1", 32'(y1()), 32'(low_hot(i)));
      sel[3:2] = 2'(i + 1);
    end
    cyc(); chk("indep_ch0_done", 32'(done[0]), 32'h1);

    // Mode 1->0 while idle resumes level decode next edge
    set_ch(0, 1'b0, 1'b0, 3, 1'b0, 0);
    cyc(); chk("mode_back", 32'(y0()), 32'h7);

    // Asynchronous reset mid-pulse
    set_ch(0, 1'b0, 1'b1, 2, 1'b1, 6);
    cyc(); start[0] = 1'b0;
    cyc();
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_y", 32'(y_n), 32'hFF);
    chk("async_rst_busy", 32'(busy), 32'h0);
    chk("async_rst_done", 32'(done), 32'h0);
    cyc(); reset_n = 1'b1;
    cyc(); chk("post_rst_done", 32'(done[0]), 32'h0);

    // Random run, checked by the scoreboard
    mode = '0;
    for (int n = 0; n < 3000; n++) begin
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(0, 15) == 0) mode[c] = ~mode[c];
        en_n[c] = ($urandom_range(0, 7) == 0);
        start[c] = ($urandom_range(0, 3) == 0);
        sel[c*SW +: SW] = SW'($urandom_range(0, OUTS - 1));
        pulse_len[c*LW +: LW] = LW'($urandom_range(0, 15));
      end
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/strobe_decoder_n.md
Name: strobe_decoder_n

Overview:
Parametrised, registered successor to the dual 2-to-4 decoder parts. It provides CHANNELS independent SEL_W-to-2^SEL_W decoders with active-low one-hot outputs and active-low enables. Each channel runs in either level mode (registered decode) or pulse mode (a timed strobe of programmable length with busy/done status). It generates memory, bus and register-file select strobes, replacing discrete decoders plus one-shot timing.

Parameters:
CHANNELS, 2, number of independent decoder channels
SEL_W, 2, select width per channel; outputs per channel = 2^SEL_W
LEN_W, 4, width of the per-channel pulse-length field

Ports:
clk  input  1  system clock, all state on rising edge
reset_n  input  1  asynchronous active-low reset
en_n  input  CHANNELS  per-channel active-low enable (G)
mode  input  CHANNELS  0 = level mode, 1 = pulse mode
sel  input  CHANNELS*SEL_W  per-channel select; channel c uses bits [c*SEL_W +: SEL_W]
start  input  CHANNELS  pulse-mode request, sampled on clk
pulse_len  input  CHANNELS*LEN_W  strobe length in cycles; 0 is treated as 1
y_n  output  CHANNELS*2^SEL_W  active-low one-hot outputs; channel c uses [c*2^SEL_W +: 2^SEL_W]
busy  output  CHANNELS  channel is emitting a pulse-mode strobe
done  output  CHANNELS  one-cycle completion flag for pulse mode

Behaviour:
- Reset (reset_n low, asynchronous): all y_n = 1, busy = 0, done = 0, counters and latched selects = 0, every channel in IDLE. Release is synchronous to the next clk edge.
- Channels are fully independent. The rules below apply per channel.
- All outputs are registered. There is no combinational path from inputs to outputs.
- Level mode (mode=0 and channel IDLE):
  - Each edge: y_n <= en_n ? all-ones : ~(1 << sel).
  - Latency is 1 cycle.
  - busy = 0, done = 0.
- Pulse mode state machine: states IDLE and ACTIVE.
- IDLE -> ACTIVE when start=1, en_n=0 and mode=1 at a clk edge.
  - The edge latches sel into sel_q.
  - It loads cnt = max(pulse_len, 1).
  - y_n <= ~(1 << sel_q) and busy <= 1.
- IDLE with mode=1 and no accepted start: y_n all-ones. start while en_n=1 is ignored.
- ACTIVE, each edge:
  - If en_n=1: abort. Go to IDLE with y_n all-ones, busy=0, done stays 0.
  - Else if cnt=1: go to IDLE with y_n all-ones, busy=0, done<=1.
  - Else: cnt <= cnt-1 and hold y_n.
- Timing: start sampled at edge t gives y_n low for exactly L cycles (edges t..t+L-1 launch it), busy high over the same cycles, and done high for the one cycle after the last strobe cycle.
- done is a single-cycle pulse. It clears on the next edge unless a new completion occurs.
- In ACTIVE:
  - start is ignored.
  - Changes to sel, pulse_len and mode are ignored until IDLE; mode and pulse_len are sampled only at start.
- Back-to-back: a start in the cycle where done=1 (channel IDLE) is accepted. The minimum gap between strobes is 1 cycle with all outputs high, so two strobes are never merged.
- At most one output bit per channel is low at any time. This holds in all modes, transitions and abort.
- mode switched 1->0 while IDLE: level decode resumes on the next edge.
- reset_n asserted mid-pulse: outputs go high immediately (asynchronously), with no done.

Test Plan:
- Reset/level: assert reset_n=0 mid-operation -> all y_n=1 immediately. Release, mode=0, en_n=0, sel=2 (SEL_W=2) -> channel y_n=4'b1011 one cycle later. en_n=1 -> 4'b1111 next cycle.
- Pulse basic: mode=1, pulse_len=3, sel=1, start for 1 cycle -> y_n=4'b1101 for exactly 3 cycles, busy=1 for those 3, then done=1 for 1 cycle with y_n=4'b1111.
- Zero length and back-to-back: pulse_len=0 -> 1-cycle strobe. Then start during the done cycle with sel=3, len=2 -> 1 cycle all-high, then 4'b0111 for 2 cycles.
- Abort and ignore: start len=5, raise en_n on 2nd strobe cycle -> y_n all-high next cycle, busy=0, no done. start and sel changes during ACTIVE have no effect on the current strobe.
- Independence: CHANNELS=2, ch0 pulse len=4 and ch1 level mode toggling sel every cycle simultaneously -> each channel matches its own model with no cross-coupling. One-hot-low invariant is checked by assertion throughout a random run.
